// File: rtl/dither_stream_ctrl_if.sv
// Valid/ready pixel stream carrying frame/line markers.
// The master drives valid/data/sof/eol and the slave drives ready.
interface dither_stream_ctrl_if #(
   parameter int unsigned W = 32
);
   logic         valid;
   logic         ready;
   logic [W-1:0] data;
   logic         sof;
   logic         eol;

   modport master (output valid, data, sof, eol, input ready);
   modport slave  (input valid, data, sof, eol, output ready);
endinterface

// File: rtl/dither_stream_ctrl.sv
// Stream sequencer for the blue-noise dither datapath: noise-table positioning, vin alignment, output FIFO.
// Optional per-frame noise offset shift is enabled by defining TEMPORAL_DITHER_EN.
module dither_stream_ctrl #(
   parameter int unsigned OUTPUT_BITS  = 1,
   parameter int unsigned FRAME_X_STEP = 5,
   parameter int unsigned FRAME_Y_STEP = 23
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     dither_en,
   dither_stream_ctrl_if.slave      s,
   dither_stream_ctrl_if.master     m,
   output logic [3:0]               dither_x_pos,
   output logic [5:0]               dither_y_pos,
   output logic [31:0]              dither_vin,
   input  logic [OUTPUT_BITS*4-1:0] dither_vout
);
   localparam int unsigned OW    = OUTPUT_BITS * 4;
   localparam logic [3:0]  StepX = 4'(FRAME_X_STEP % 16);
   localparam logic [5:0]  StepY = 6'(FRAME_Y_STEP % 64);

   typedef struct packed {
      logic [OW-1:0] data;
      logic          sof;
      logic          eol;
   } entry_t;

   logic        acc;
   logic        s_ready;
   logic [3:0]  in_flight;
   logic [3:0]  x_cnt_q, x_cnt_d, x_pos_q, x_eff, x_off, off_x, pos_x;
   logic [5:0]  y_cnt_q, y_cnt_d, y_pos_q, y_eff, y_off, off_y, pos_y;

   logic        s1_v_q, s1_sof_q, s1_eol_q;
   logic [31:0] vin_q;
   logic        s2_v_q, s2_sof_q, s2_eol_q;
   logic [31:0] s2_data_q;

   entry_t      fifo_q [4];
   entry_t      wr_entry;
   logic [1:0]  wr_ptr_q, rd_ptr_q;
   logic [2:0]  cnt_q, cnt_d;
   logic        fifo_nempty, wr, rd;
   logic [OW-1:0] bypass;

   // Credit check uses registers only, so m.ready never reaches s.ready combinationally.
   assign in_flight = 4'(cnt_q) + 4'(s1_v_q) + 4'(s2_v_q);
   assign s_ready   = !rst && (in_flight < 4'd4);
   assign s.ready   = s_ready;
   assign acc       = s.valid & s_ready;

`ifdef TEMPORAL_DITHER_EN
   localparam bit TemporalEn = 1'b1;
   logic [3:0] x_off_q;
   logic [5:0] y_off_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_off_q <= '0;
         y_off_q <= '0;
      end else if (acc && s.sof) begin
         x_off_q <= off_x;
         y_off_q <= off_y;
      end
   end

   assign x_off = x_off_q;
   assign y_off = y_off_q;
`else
   localparam bit TemporalEn = 1'b0;
   assign x_off = '0;
   assign y_off = '0;
`endif

   always_comb begin
      x_eff   = s.sof ? '0 : x_cnt_q;
      y_eff   = s.sof ? '0 : y_cnt_q;
      off_x   = (TemporalEn && s.sof) ? x_off + StepX : x_off;
      off_y   = (TemporalEn && s.sof) ? y_off + StepY : y_off;
      pos_x   = x_eff + off_x;
      pos_y   = y_eff + off_y;
      x_cnt_d = x_cnt_q;
      y_cnt_d = y_cnt_q;
      if (acc) begin
         if (s.eol) begin
            x_cnt_d = '0;
            y_cnt_d = y_eff + 6'd1;
         end else begin
            x_cnt_d = x_eff + 4'd1;
            y_cnt_d = y_eff;
         end
      end
   end

   assign dither_x_pos = acc ? pos_x : x_pos_q;
   assign dither_y_pos = acc ? pos_y : y_pos_q;
   assign dither_vin   = vin_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_cnt_q <= '0;
         y_cnt_q <= '0;
         x_pos_q <= '0;
         y_pos_q <= '0;
      end else begin
         x_cnt_q <= x_cnt_d;
         y_cnt_q <= y_cnt_d;
         if (acc) begin
            x_pos_q <= pos_x;
            y_pos_q <= pos_y;
         end
      end
   end

   // Fixed two-stage pipeline matching the dither block's BRAM read latency; it never stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v_q    <= 1'b0;
         s1_sof_q  <= 1'b0;
         s1_eol_q  <= 1'b0;
         vin_q     <= '0;
         s2_v_q    <= 1'b0;
         s2_sof_q  <= 1'b0;
         s2_eol_q  <= 1'b0;
         s2_data_q <= '0;
      end else begin
         s1_v_q    <= acc;
         s1_sof_q  <= s.sof;
         s1_eol_q  <= s.eol;
         if (acc) vin_q <= s.data;
         s2_v_q    <= s1_v_q;
         s2_sof_q  <= s1_sof_q;
         s2_eol_q  <= s1_eol_q;
         s2_data_q <= vin_q;
      end
   end

   assign bypass = {s2_data_q[31 -: OUTPUT_BITS], s2_data_q[23 -: OUTPUT_BITS],
                    s2_data_q[15 -: OUTPUT_BITS], s2_data_q[7 -: OUTPUT_BITS]};

   assign fifo_nempty = (cnt_q != 3'd0);
   assign wr          = s2_v_q;
   assign rd          = fifo_nempty & m.ready;

   always_comb begin
      wr_entry.data = dither_en ? dither_vout : bypass;
      wr_entry.sof  = s2_sof_q;
      wr_entry.eol  = s2_eol_q;
      cnt_d         = cnt_q + 3'(wr) - 3'(rd);
   end

   always_ff @(posedge clk) begin
      if (wr) fifo_q[wr_ptr_q] <= wr_entry;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (wr) wr_ptr_q <= wr_ptr_q + 2'd1;
         if (rd) rd_ptr_q <= rd_ptr_q + 2'd1;
         cnt_q <= cnt_d;
      end
   end

   assign m.valid = fifo_nempty;
   assign m.data  = fifo_q[rd_ptr_q].data;
   assign m.sof   = fifo_q[rd_ptr_q].sof;
   assign m.eol   = fifo_q[rd_ptr_q].eol;
endmodule

// File: doc/dither_stream_ctrl.md
Name: dither_stream_ctrl

Overview:
- Stream-side sequencer for the blue noise dithering datapath. Takes a valid/ready stream of 32-bit words (4 x 8-bit pixels) with frame and line markers.
- Generates the noise-table position (x_pos/y_pos) for every word and aligns vin with the dither block's BRAM read timing.
- Captures the dithered result into an output FIFO that absorbs the pipeline latency. Presents a valid/ready stream of packed OUTPUT_BITS*4-bit words to the downstream packer.

Parameters:
- OUTPUT_BITS, 1: bits per output pixel, 1 or 4. Must match the dither instance.
- FRAME_X_STEP, 5: per-frame x_pos offset increment, mod 16. Used only with TEMPORAL_DITHER_EN.
- FRAME_Y_STEP, 23: per-frame y_pos offset increment, mod 64. Used only with TEMPORAL_DITHER_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- dither_en  in  1  1 = use dithered result; 0 = bypass (truncate each byte to its top OUTPUT_BITS)
- s_valid  in  1  input word valid
- s_ready  out  1  input word accepted when s_valid & s_ready
- s_data  in  32  pixels, [31:24] first
- s_sof  in  1  word is first of frame
- s_eol  in  1  word is last of line
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accepts
- m_data  out  OUTPUT_BITS*4  packed pixels, same order as s_data
- m_sof  out  1  delayed s_sof
- m_eol  out  1  delayed s_eol
- dither_x_pos  out  4  to dither block
- dither_y_pos  out  6  to dither block
- dither_vin  out  32  to dither block
- dither_vout  in  OUTPUT_BITS*4  from dither block

Behaviour:
- Clock and reset: one clock clk. Reset rst is asynchronous and active-high.
- Reset values: FIFO empty, m_valid=0, stage valids=0, x_cnt=0, y_cnt=0, x_off=0, y_off=0, dither_vin=0.
  - s_ready=0 while rst is asserted; s_ready=1 in the first cycle after release.
  - Reset mid-frame discards all in-flight and buffered words.
- Accept: beat is accepted at cycle T when s_valid & s_ready.
- Position for an accepted beat:
  - x_eff = sof ? 0 : x_cnt; y_eff = sof ? 0 : y_cnt.
  - off = sof ? (x_off+FRAME_X_STEP, y_off+FRAME_Y_STEP) : (x_off, y_off).
  - dither_x_pos = (x_eff + off_x) mod 16 and dither_y_pos = (y_eff + off_y) mod 64, both driven combinationally during T.
  - When no beat is accepted, the position outputs hold their last accepted value.
- Counter update on accept:
  - eol=1: x_cnt<=0, y_cnt<=y_eff+1 (wraps 63->0).
  - Otherwise: x_cnt<=x_eff+1 (wraps 15->0), y_cnt<=y_eff.
  - sof=1: the offset registers take off. sof and eol may both be set on the same beat; the rules compose.
- Pipeline:
  - Stage1 (cycle T+1): dither_vin = registered s_data; stage1 valid/sof/eol registered. The BRAM noise is valid in this cycle.
  - Stage2 (cycle T+2): dither_vout is valid. Stage2 holds a copy of the data for bypass.
  - FIFO write at the end of T+2; m_valid is visible at T+3 when the FIFO was empty. Minimum latency s->m is 3 cycles.
  - Stages have no stall. Flow control is credit-based only.
- FIFO: 4 entries, holding {data, sof, eol}.
  - s_ready = (fifo_count + stage1_valid + stage2_valid) < 4, computed from registers only. There is no combinational path from m_ready to s_ready.
  - Sustains 1 word/cycle when m_ready is held 1.
  - Simultaneous write and read: count is unchanged.
  - Overflow cannot occur by construction; the bench asserts this.
- Bypass: with dither_en=0, FIFO data = {s[31-:OB], s[23-:OB], s[15-:OB], s[7-:OB]} from stage2 data.
  - dither_en is sampled at FIFO write. Changing it mid-frame takes effect per word.
- Output: m_data/m_sof/m_eol reflect the FIFO head. They are stable while m_valid & !m_ready.

Optional Feature:
- Macro TEMPORAL_DITHER_EN.
- Defined: x_off/y_off advance by FRAME_X_STEP/FRAME_Y_STEP on each accepted sof, so the noise pattern shifts per frame to reduce fixed-pattern artefacts on e-paper.
- Undefined: offset registers are removed and offsets are constant 0. The position is purely (x_cnt, y_cnt).

Test Plan:
- Reset release, single beat with s_sof=1, s_data=32'h00FF8040, dither_en=0, OUTPUT_BITS=1, m_ready=1 -> positions (0,0) in the accept cycle; m_valid exactly 3 cycles later with m_data=4'b0110 and m_sof=1.
- Continuous stream of 40 beats, eol on every 20th beat, m_ready=1 -> s_ready never drops. x_pos sequence 0..15,0..3 then back to 0; y_pos increments to 1 after the first eol.
- Continuous input with m_ready=0 -> exactly 4 beats accepted, then s_ready=0. Set m_ready=1 -> the 4 words emerge in order, then throughput resumes at 1/cycle with no loss or duplication.
- Two frames (sof at beats 0 and N) with TEMPORAL_DITHER_EN defined -> frame-1 first position (5,23), frame-2 first position (10,46). Undefined -> (0,0) both times.
- Random s_valid/m_ready for 10k beats against a reference model, dither block instantiated with noise.mem -> output matches model bit-exact, FIFO never overflows.
- rst asserted with 3 words in flight/buffered -> m_valid=0 immediately; after release the first new beat is output with no stale data and counters restart at (0,0).
